// File: rtl/sha256_constants.sv
// SHA-256 word/state types, round constants, initial hash value and the
// sigma/Sigma/Ch/Maj helper functions shared by the compression datapath.
package sha256_constants;

    typedef logic [31:0] sha_word_t;
    // Index 7 holds H0 / working variable a, index 0 holds H7 / h.
    typedef sha_word_t [7:0] sha_state_t;

    localparam sha_state_t H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sha_word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic sha_word_t rotr(input sha_word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sha_word_t small_sigma0(input sha_word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic sha_word_t small_sigma1(input sha_word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic sha_word_t big_sigma0(input sha_word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic sha_word_t big_sigma1(input sha_word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic sha_word_t ch(input sha_word_t e, input sha_word_t f, input sha_word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic sha_word_t maj(input sha_word_t a, input sha_word_t b, input sha_word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-in / digest-out handshake bundle of the SHA-256 compression engine.
interface sha256_compress_if;

    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic         init;
    logic         dbl;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest_out;

    modport master (
        output in_valid, block_in, init, dbl, out_ready,
        input  in_ready, out_valid, digest_out
    );

    modport slave (
        input  in_valid, block_in, init, dbl, out_ready,
        output in_ready, out_valid, digest_out
    );

endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window, W_t presented at w_o,
// next word generated in place as the window shifts.
module sha256_msg_sched
    import sha256_constants::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [511:0] block_i,
    output sha_word_t    w_o
);

    localparam int unsigned WIN = 16;

    sha_word_t win_q [WIN];

    // Slot 0 holds W_t; slot 15 receives W_t+16 on every shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
        end else if (load_i) begin
            for (int unsigned i = 0; i < WIN; i++) win_q[i] <= block_i[511 - 32*i -: 32];
        end else if (shift_i) begin
            for (int unsigned i = 0; i < WIN - 1; i++) win_q[i] <= win_q[i + 1];
            win_q[WIN-1] <= small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
        end
    end

    assign w_o = win_q[0];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression, one round per clock. Define SHA256_DBL_EN to
// honour the dbl request (second pass over the padded first digest).
module sha256_compress
    import sha256_constants::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    sha256_compress_if.slave bus
);

    localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    sha_state_t       work_q;
    sha_state_t       base_q;
    sha_state_t       chain_q;
    logic [255:0]     digest_q;
    logic             in_ready_q;
    logic             out_valid_q;

    sha_word_t        w_c;
    sha_word_t        t1_c;
    sha_word_t        t2_c;
    sha_state_t       work_d;
    sha_state_t       sum_c;
    sha_state_t       start_c;
    logic             accept_c;
    logic             last_c;
    logic             load_c;
    logic [511:0]     load_blk_c;

`ifdef SHA256_DBL_EN
    logic dbl_q;
    logic pass2_q;
    logic reload_q;
`else
    logic unused_dbl_c;
    assign unused_dbl_c = bus.dbl;
`endif

    assign accept_c = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign last_c   = (cnt_q == CNT_W'(ROUNDS - 1));
    assign start_c  = bus.init ? H_INIT : chain_q;

`ifdef SHA256_DBL_EN
    // Second pass consumes the first digest padded as a 256-bit message.
    assign load_c     = accept_c || ((state_q == ROUND) && reload_q);
    assign load_blk_c = accept_c ? bus.block_in
                                 : {chain_q, 32'h80000000, 192'h0, 32'h00000100};
`else
    assign load_c     = accept_c;
    assign load_blk_c = bus.block_in;
`endif

    sha256_msg_sched u_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .shift_i (state_q == ROUND),
        .block_i (load_blk_c),
        .w_o     (w_c)
    );

    // One compression round plus the feed-forward sum used on the last round.
    always_comb begin
        t1_c   = work_q[0] + big_sigma1(work_q[3]) + ch(work_q[3], work_q[2], work_q[1])
               + K[cnt_q] + w_c;
        t2_c   = big_sigma0(work_q[7]) + maj(work_q[7], work_q[6], work_q[5]);
        work_d = {t1_c + t2_c, work_q[7], work_q[6], work_q[5],
                  work_q[4] + t1_c, work_q[3], work_q[2], work_q[1]};
        for (int i = 0; i < 8; i++) sum_c[i] = base_q[i] + work_d[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= H_INIT;
            base_q      <= H_INIT;
            chain_q     <= H_INIT;
            digest_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SHA256_DBL_EN
            dbl_q       <= 1'b0;
            pass2_q     <= 1'b0;
            reload_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        work_q     <= start_c;
                        base_q     <= start_c;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ROUND;
`ifdef SHA256_DBL_EN
                        dbl_q      <= bus.dbl;
                        pass2_q    <= 1'b0;
`endif
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ROUND: begin
`ifdef SHA256_DBL_EN
                    if (reload_q) begin
                        work_q   <= H_INIT;
                        base_q   <= H_INIT;
                        cnt_q    <= '0;
                        reload_q <= 1'b0;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= last_c ? '0 : cnt_q + 1'b1;
                        if (last_c && dbl_q) begin
                            chain_q  <= sum_c;
                            dbl_q    <= 1'b0;
                            pass2_q  <= 1'b1;
                            reload_q <= 1'b1;
                        end else if (last_c) begin
                            if (!pass2_q) chain_q <= sum_c;
                            digest_q    <= sum_c;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
`else
                    work_q <= work_d;
                    cnt_q  <= last_c ? '0 : cnt_q + 1'b1;
                    if (last_c) begin
                        chain_q     <= sum_c;
                        digest_q    <= sum_c;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.digest_out = digest_q;

endmodule
